// File: rtl/line_follower_pwm_if.sv
// Host-side control and motor-drive bundle for the line follower controller.
// The host drives enable and the raw sensors; the controller drives the rest.
interface line_follower_pwm_if #(
    parameter int N_SENSORS = 4
);
    logic                 enable;
    logic [N_SENSORS-1:0] sensors;
    logic                 motorLeft;
    logic                 motorRight;
    logic [2:0]           state;
    logic                 lineLost;

    modport master (
        output enable,
        output sensors,
        input  motorLeft,
        input  motorRight,
        input  state,
        input  lineLost
    );

    modport slave (
        input  enable,
        input  sensors,
        output motorLeft,
        output motorRight,
        output state,
        output lineLost
    );
endinterface

// File: rtl/line_follower_pwm.sv
// Line follower controller: debounces the sensor bar, steers a tracking FSM and
// drives two PWM motor outputs whose duty only changes on PWM period boundaries.
module line_follower_pwm #(
    parameter int                   N_SENSORS    = 4,
    parameter int                   PWM_WIDTH    = 8,
    parameter int                   DEBOUNCE     = 4,
    parameter int                   LOST_TIMEOUT = 1000,
    parameter logic [PWM_WIDTH-1:0] FAST_DUTY    = PWM_WIDTH'(200),
    parameter logic [PWM_WIDTH-1:0] SLOW_DUTY    = PWM_WIDTH'(80)
) (
    input logic                clk,
    input logic                reset,
    line_follower_pwm_if.slave bus
);

    localparam int HALF = N_SENSORS / 2;
    localparam int CW   = $clog2(HALF + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FORWARD    = 3'd1,
        TURN_LEFT  = 3'd2,
        TURN_RIGHT = 3'd3,
        SEARCH     = 3'd4,
        STOP       = 3'd5
    } stateT;

    stateT                stateQ;
    stateT                stateD;
    logic [N_SENSORS-1:0] sensReg;
    logic [N_SENSORS-1:0] dbn;
    logic [7:0]           stableCnt;
    logic [15:0]          lostCnt;
    logic                 lastDir;
    logic [CW-1:0]        cntL;
    logic [CW-1:0]        cntR;
    logic [PWM_WIDTH-1:0] pwmCnt;
    logic [PWM_WIDTH-1:0] dutyL;
    logic [PWM_WIDTH-1:0] dutyR;
    logic [PWM_WIDTH-1:0] targetL;
    logic [PWM_WIDTH-1:0] targetR;
    logic                 lostFlag;
    logic                 haltNext;
    logic                 motorL;
    logic                 motorR;

    // The raw bar is registered once; dbn only follows it after it has held still.
    always_ff @(posedge clk) begin
        if (reset) begin
            sensReg   <= '0;
            dbn       <= '0;
            stableCnt <= '0;
        end else begin
            sensReg <= bus.sensors;
            if (bus.sensors != sensReg) begin
                stableCnt <= '0;
            end else if (stableCnt == 8'(DEBOUNCE - 1)) begin
                dbn <= sensReg;
            end else begin
                stableCnt <= stableCnt + 8'd1;
            end
        end
    end

    always_comb begin
        cntL = '0;
        cntR = '0;
        for (int i = 0; i < HALF; i++) begin
            cntR = cntR + CW'(dbn[i]);
            cntL = cntL + CW'(dbn[i + HALF]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // enable low wins over everything; STOP is only escaped through IDLE.
    always_comb begin
        stateD = stateQ;
        if (!bus.enable) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE, FORWARD, TURN_LEFT, TURN_RIGHT, SEARCH: begin
                    if (dbn != '0) begin
                        if (cntL > cntR) begin
                            stateD = TURN_LEFT;
                        end else if (cntR > cntL) begin
                            stateD = TURN_RIGHT;
                        end else begin
                            stateD = FORWARD;
                        end
                    end else if (stateQ == IDLE) begin
                        stateD = IDLE;
                    end else if (stateQ == SEARCH && lostCnt == 16'(LOST_TIMEOUT - 1)) begin
                        stateD = STOP;
                    end else begin
                        stateD = SEARCH;
                    end
                end
                STOP:    stateD = STOP;
                default: stateD = IDLE;
            endcase
        end
    end

    always_comb begin
        targetL  = '0;
        targetR  = '0;
        lostFlag = 1'b0;
        case (stateQ)
            FORWARD: begin
                targetL = FAST_DUTY;
                targetR = FAST_DUTY;
            end
            TURN_LEFT: begin
                targetL = SLOW_DUTY;
                targetR = FAST_DUTY;
            end
            TURN_RIGHT: begin
                targetL = FAST_DUTY;
                targetR = SLOW_DUTY;
            end
            SEARCH: begin
                lostFlag = 1'b1;
                if (lastDir) begin
                    targetL = SLOW_DUTY;
                end else begin
                    targetR = SLOW_DUTY;
                end
            end
            STOP:    lostFlag = 1'b1;
            default: ;
        endcase
    end

    // lostCnt sits at zero outside SEARCH, so every entry starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            lostCnt <= '0;
            lastDir <= 1'b0;
        end else begin
            if (stateQ != SEARCH) begin
                lostCnt <= '0;
            end else begin
                lostCnt <= lostCnt + 16'd1;
            end
            if (stateD == TURN_LEFT && stateQ != TURN_LEFT) begin
                lastDir <= 1'b0;
            end else if (stateD == TURN_RIGHT && stateQ != TURN_RIGHT) begin
                lastDir <= 1'b1;
            end
        end
    end

    assign haltNext = (stateD == IDLE) || (stateD == STOP);

    // Duty is latched on the counter wrap so a period never mixes two duties;
    // halting states bypass that and silence the motors at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwmCnt <= '0;
            dutyL  <= '0;
            dutyR  <= '0;
            motorL <= 1'b0;
            motorR <= 1'b0;
        end else begin
            pwmCnt <= pwmCnt + PWM_WIDTH'(1);
            if (haltNext) begin
                dutyL <= '0;
                dutyR <= '0;
            end else if (pwmCnt == '1) begin
                dutyL <= targetL;
                dutyR <= targetR;
            end
            motorL <= !haltNext && (pwmCnt < dutyL);
            motorR <= !haltNext && (pwmCnt < dutyR);
        end
    end

    assign bus.state      = stateQ;
    assign bus.lineLost   = lostFlag;
    assign bus.motorLeft  = motorL;
    assign bus.motorRight = motorR;

endmodule

// File: doc/line_follower_pwm.md
LINE_FOLLOWER_PWM -- requirements
Module: line_follower_pwm

Interface
REQ-001 Parameter N_SENSORS, default 4, is the number of line sensors; it SHALL be even and at least 2.
REQ-002 Parameter PWM_WIDTH, default 8, is the width of the PWM counter and duty values.
REQ-003 Parameter DEBOUNCE, default 4, is the number of consecutive stable cycles required before the debounced sensor vector updates; its range SHALL be 1..255.
REQ-004 Parameter LOST_TIMEOUT, default 1000, is the number of SEARCH cycles allowed before entering STOP; its range SHALL be 1..2^16-1.
REQ-005 Parameters FAST_DUTY (default 200) and SLOW_DUTY (default 80) are motor duty values of width PWM_WIDTH.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  run request; low forces IDLE.
REQ-009 sensors  input  N_SENSORS  raw sensor vector, 1 = line seen; bit N_SENSORS-1 is leftmost.
REQ-010 motorLeft  output  1  registered PWM drive for the left motor.
REQ-011 motorRight  output  1  registered PWM drive for the right motor.
REQ-012 state  output  3  current FSM state code.
REQ-013 lineLost  output  1  high while in SEARCH or STOP.

Function
REQ-014 Debounce: the raw vector SHALL be registered once; the debounced vector dbn SHALL load the registered value after it has been identical for DEBOUNCE consecutive cycles; any change SHALL restart the stability count.
REQ-015 Position: cntL SHALL be the popcount of dbn[N-1:N/2] and cntR the popcount of dbn[N/2-1:0].
REQ-016 State encoding: IDLE=0, FORWARD=1, TURN_LEFT=2, TURN_RIGHT=3, SEARCH=4, STOP=5; codes 6 and 7 SHALL return to IDLE on the next cycle.
REQ-017 enable=0 SHALL force IDLE on the next edge from any state, with priority over every other transition.
REQ-018 In IDLE, FORWARD, TURN_LEFT, TURN_RIGHT or SEARCH with enable=1, the next state SHALL follow dbn: dbn nonzero with cntL==cntR -> FORWARD; cntL>cntR -> TURN_LEFT; cntR>cntL -> TURN_RIGHT.
REQ-019 In those same states, dbn==0 SHALL select the following next state: SEARCH from a tracking state, IDLE from IDLE, and SEARCH or STOP from SEARCH as defined in REQ-021.
REQ-020 Register lastDir SHALL be set to 0 on entry to TURN_LEFT and to 1 on entry to TURN_RIGHT; it SHALL be unchanged by FORWARD and reset to 0.
REQ-021 SEARCH: a 16-bit lost counter SHALL clear on entry and increment each SEARCH cycle; when it reaches LOST_TIMEOUT-1 while dbn==0, the next state SHALL be STOP.
REQ-022 STOP SHALL be left only through IDLE, via enable=0.
REQ-023 Target duty per state (left, right): IDLE/STOP (0,0); FORWARD (FAST,FAST); TURN_LEFT (SLOW,FAST); TURN_RIGHT (FAST,SLOW); SEARCH with lastDir=0 (0,SLOW); SEARCH with lastDir=1 (SLOW,0).
REQ-024 The PWM counter SHALL be PWM_WIDTH bits wide, free-running, incrementing every cycle and wrapping from 2^W-1 to 0.
REQ-025 Active duty registers SHALL load the target duty only in the cycle the counter equals 2^W-1, so that every PWM period uses a single duty value.
REQ-026 The motor outputs SHALL be registered: motorX <= (pwmCnt < activeDutyX); duty 0 gives a constant 0, and duty 2^W-1 gives 2^W-1 high cycles per 2^W.
REQ-027 Exception to REQ-025: entry to IDLE or STOP SHALL zero both active duties immediately, so motors are low from the cycle after entry.
REQ-028 Latency from a raw sensor change to a state change SHALL be DEBOUNCE+2 cycles.

Reset
REQ-029 reset=1 SHALL take effect on the next clk edge: state=IDLE, motorLeft=0, motorRight=0, lineLost=0, pwmCnt=0, both active duties 0, dbn=0, debounce and lost counters 0, lastDir=0.
REQ-030 Reset asserted mid-operation, including mid-PWM-period and mid-SEARCH, SHALL have the same effect as reset at power-up and SHALL override enable.

Verification (N=4, W=4, DEBOUNCE=3, LOST_TIMEOUT=20, FAST=12, SLOW=4)
REQ-031 Reset, then enable=1, sensors=0110 held -> state=1 after 5 cycles; each motor then shows 12 high and 4 low cycles per 16-cycle period.
REQ-032 sensors=1100 -> state=2, motorLeft 4 of 16 high, motorRight 12 of 16 high; then sensors=0011 -> state=3 with duties swapped.
REQ-033 sensors glitch 0110->1000 for 2 cycles then back -> no state change and no duty change.
REQ-034 From TURN_RIGHT apply sensors=0000 -> state=4, lineLost=1, motorLeft 4 of 16 high, motorRight 0; after 20 SEARCH cycles -> state=5, both motors 0; line restored within 20 cycles -> state=1.
REQ-035 In STOP, sensors=0110 -> remains 5; enable=0 -> state=0; enable=1 -> state=1.
REQ-036 reset pulsed while motors are high mid-period -> all outputs 0 on the next edge; state=0.
